sub_8bit_serial: RTL

SUB_8BIT_SERIAL -- requirements
Module: sub_8bit_serial

---
 rtl/arith_pkg.sv | 13 +
 rtl/full_subtractor.sv | 15 +
 rtl/sub_8bit_serial.sv | 95 +++++++++
 3 files changed

// File: rtl/arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: controller states
// and the default operand width.
package arith_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, with bout raised when a < b + bin.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  always_comb begin
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

// File: rtl/sub_8bit_serial.sv
// Bit-serial subtractor: one bit per cycle, LSB first, through a single full
// subtractor; the result is published together with a one-cycle done pulse.
module sub_8bit_serial
  import arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout,
  output logic             Ovf
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] a_q, b_q, diff_sh;
  logic             borrow_q;
  logic             fs_d, fs_bout;
  logic             accept;

  // Signed overflow of a - b: operand signs differ and the result sign
  // disagrees with the minuend.
  function automatic logic sub_ovf(input logic a_msb, input logic b_msb,
                                   input logic d_msb);
    return (a_msb != b_msb) && (d_msb != a_msb);
  endfunction

  full_subtractor u_fs (
    .a   (a_q[idx]),
    .b   (b_q[idx]),
    .bin (borrow_q),
    .d   (fs_d),
    .bout(fs_bout)
  );

  always_comb begin
    state_nxt = state;
    ready     = (state == IDLE);
    accept    = (state == IDLE) && start;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (idx == LAST_IDX) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture and serial bit stage; the borrow ripples one bit per edge.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q      <= A;
      b_q      <= B;
      borrow_q <= Bin;
    end else if (state == RUN) begin
      diff_sh[idx] <= fs_d;
      borrow_q     <= fs_bout;
    end
  end

  // Control and result publication; outputs only move on the DONE edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      done  <= 1'b0;
      Diff  <= '0;
      Bout  <= 1'b0;
      Ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= (state == DONE);
      if (accept) begin
        idx <= '0;
      end else if (state == RUN) begin
        idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
      end
      if (state == DONE) begin
        Diff <= diff_sh;
        Bout <= borrow_q;
        Ovf  <= sub_ovf(a_q[WIDTH-1], b_q[WIDTH-1], diff_sh[WIDTH-1]);
      end
    end
  end

endmodule
